// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use, ECALL operand,
// mispredict flush and data-memory wait handling, with saturating stall/flush counters.
module hazard_control_unit #(
    parameter int NUM_STAGES   = 2,
    parameter int ECALL_DEPTH  = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              id_opcode,
    input  logic [4:0]              id_rs1,
    input  logic [4:0]              id_rs2,
    input  logic [5*NUM_STAGES-1:0] stage_rd,
    input  logic [NUM_STAGES-1:0]   stage_reg_write,
    input  logic                    ex_mem_read,
    input  logic                    ex_mispredict,
    input  logic                    dmem_req,
    input  logic                    dmem_ready,
    output logic                    pc_write,
    output logic                    if_id_write,
    output logic                    id_ex_nop,
    output logic                    if_id_flush,
    output logic                    pipe_freeze,
    output logic [CNT_W-1:0]        stall_count,
    output logic [CNT_W-1:0]        flush_count
);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [2:0]            r_flush_left;
    logic [2:0]            w_flush_left_next;
    logic [CNT_W-1:0]      r_stall_count;
    logic [CNT_W-1:0]      r_flush_count;
    logic                  w_flush_event;
    logic                  w_rs1_used;
    logic                  w_rs2_used;
    logic                  w_is_ecall;
    logic [NUM_STAGES-1:0] w_match;
    logic                  w_load_use;
    logic                  w_ecall_hazard;
    logic                  w_mem_wait;
    logic                  w_flushing;

    assign w_is_ecall = (id_opcode == OP_ECALL);
    assign w_rs1_used = (id_rs1 != 5'd0) &&
                        ((id_opcode == OP_ARITH) || (id_opcode == OP_ARITH_IMM) ||
                         (id_opcode == OP_LOAD)  || (id_opcode == OP_STORE)     ||
                         (id_opcode == OP_BRANCH) || (id_opcode == OP_JALR)     ||
                         w_is_ecall);
    assign w_rs2_used = (id_rs2 != 5'd0) &&
                        ((id_opcode == OP_ARITH) || (id_opcode == OP_STORE) ||
                         (id_opcode == OP_BRANCH));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_match
            logic [4:0] w_rd;
            assign w_rd        = stage_rd[5*gi +: 5];
            assign w_match[gi] = stage_reg_write[gi] && (w_rd != 5'd0) &&
                                 ((w_rs1_used && (w_rd == id_rs1)) ||
                                  (w_rs2_used && (w_rd == id_rs2)));
        end
    endgenerate

    assign w_load_use     = ex_mem_read && w_match[0];
    assign w_ecall_hazard = w_is_ecall && (|w_match[ECALL_DEPTH-1:0]);
    assign w_mem_wait     = ((r_state == ST_MEM_WAIT) || dmem_req) && !dmem_ready;
    // A flush interrupted by a memory wait keeps its remaining count and resumes on release.
    assign w_flushing     = (r_state == ST_FLUSH) ||
                            ((r_state == ST_MEM_WAIT) && (r_flush_left != 3'd0));

    always_comb begin
        pc_write          = 1'b1;
        if_id_write       = 1'b1;
        id_ex_nop         = 1'b0;
        if_id_flush       = 1'b0;
        pipe_freeze       = 1'b0;
        w_state_next      = ST_RUN;
        w_flush_left_next = r_flush_left;
        w_flush_event     = 1'b0;
        if (w_mem_wait) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_freeze  = 1'b1;
            w_state_next = ST_MEM_WAIT;
        end else if (ex_mispredict) begin
            if_id_flush       = 1'b1;
            id_ex_nop         = 1'b1;
            w_flush_left_next = FLUSH_RELOAD;
            w_state_next      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            w_flush_event     = 1'b1;
        end else if (w_flushing) begin
            if_id_flush       = 1'b1;
            id_ex_nop         = 1'b1;
            w_flush_left_next = r_flush_left - 3'd1;
            w_state_next      = (r_flush_left == 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (w_load_use || w_ecall_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_nop   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_flush_left  <= 3'd0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_flush_left <= w_flush_left_next;
            if (!pc_write && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_flush_event && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: d0 uses default parameters, d1 uses ECALL_DEPTH=1, FLUSH_CYCLES=3,
// CNT_W=4 so that saturation is reachable quickly. Both see identical stimulus.
`timescale 1ns/1ps
module tb_hazard_control_unit;

    localparam logic [6:0] OP_ADD   = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    logic       clk;
    logic       reset;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [9:0] stage_rd;
    logic [1:0] stage_reg_write;
    logic       ex_mem_read;
    logic       ex_mispredict;
    logic       dmem_req;
    logic       dmem_ready;

    logic        d0_pc_write, d0_if_id_write, d0_id_ex_nop, d0_if_id_flush, d0_pipe_freeze;
    logic        d1_pc_write, d1_if_id_write, d1_id_ex_nop, d1_if_id_flush, d1_pipe_freeze;
    logic [15:0] d0_stall, d0_flush;
    logic [3:0]  d1_stall, d1_flush;
    logic [4:0]  ctl0, ctl1;

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_write, if_id_write, id_ex_nop, if_id_flush, pipe_freeze}
    assign ctl0 = {d0_pc_write, d0_if_id_write, d0_id_ex_nop, d0_if_id_flush, d0_pipe_freeze};
    assign ctl1 = {d1_pc_write, d1_if_id_write, d1_id_ex_nop, d1_if_id_flush, d1_pipe_freeze};

    hazard_control_unit #(.NUM_STAGES(2), .ECALL_DEPTH(2), .FLUSH_CYCLES(1), .CNT_W(16)) d0 (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .stage_rd(stage_rd), .stage_reg_write(stage_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mispredict(ex_mispredict), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(d0_pc_write), .if_id_write(d0_if_id_write), .id_ex_nop(d0_id_ex_nop),
        .if_id_flush(d0_if_id_flush), .pipe_freeze(d0_pipe_freeze),
        .stall_count(d0_stall), .flush_count(d0_flush));

    hazard_control_unit #(.NUM_STAGES(2), .ECALL_DEPTH(1), .FLUSH_CYCLES(3), .CNT_W(4)) d1 (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .stage_rd(stage_rd), .stage_reg_write(stage_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mispredict(ex_mispredict), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(d1_pc_write), .if_id_write(d1_if_id_write), .id_ex_nop(d1_id_ex_nop),
        .if_id_flush(d1_if_id_flush), .pipe_freeze(d1_pipe_freeze),
        .stall_count(d1_stall), .flush_count(d1_flush));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_opcode       = OP_ADDI;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        stage_rd        = 10'd0;
        stage_reg_write = 2'b00;
        ex_mem_read     = 1'b0;
        ex_mispredict   = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read     = 1'b1;
        stage_rd        = {5'd0, 5'd5};
        stage_reg_write = 2'b01;
        id_opcode       = OP_ADD;
        id_rs1          = 5'd1;
        id_rs2          = 5'd5;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        n_checks++; if (ctl0 !== 5'b11000) begin n_fail++; $display("FAIL reset_ctl0 got=%b exp=%b", ctl0, 5'b11000); end
        n_checks++; if (ctl1 !== 5'b11000) begin n_fail++; $display("FAIL reset_ctl1 got=%b exp=%b", ctl1, 5'b11000); end
        n_checks++; if (d0_stall !== 16'd0 || d0_flush !== 16'd0) begin n_fail++; $display("FAIL reset_cnt0 got=%0d/%0d exp=0/0", d0_stall, d0_flush); end
        n_checks++; if (d1_stall !== 4'd0 || d1_flush !== 4'd0) begin n_fail++; $display("FAIL reset_cnt1 got=%0d/%0d exp=0/0", d1_stall, d1_flush); end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        set_load_use();
        #1;
        n_checks++; if (ctl0 !== 5'b00100) begin n_fail++; $display("FAIL lu_ctl0 got=%b exp=%b", ctl0, 5'b00100); end
        n_checks++; if (ctl1 !== 5'b00100) begin n_fail++; $display("FAIL lu_ctl1 got=%b exp=%b", ctl1, 5'b00100); end
        step();
        id_opcode = OP_ADDI;
        #1;
        n_checks++; if (ctl0 !== 5'b11000) begin n_fail++; $display("FAIL lu_addi_rs2_unused got=%b exp=%b", ctl0, 5'b11000); end
        n_checks++; if (d0_stall !== 16'd1) begin n_fail++; $display("FAIL lu_stall_count got=%0d exp=1", d0_stall); end
        step();
        id_opcode = OP_ADD;
        id_rs2    = 5'd0;
        stage_rd  = 10'd0;
        #1;
        n_checks++; if (ctl0 !== 5'b11000) begin n_fail++; $display("FAIL lu_x0 got=%b exp=%b", ctl0, 5'b11000); end
        step();
        set_idle();
        $display("test_load_use done");
    endtask

    task automatic test_ecall();
        id_opcode       = OP_ECALL;
        id_rs1          = 5'd17;
        stage_rd        = {5'd17, 5'd0};
        stage_reg_write = 2'b10;
        #1;
        n_checks++; if (ctl0 !== 5'b00100) begin n_fail++; $display("FAIL ecall_depth2 got=%b exp=%b", ctl0, 5'b00100); end
        n_checks++; if (ctl1 !== 5'b11000) begin n_fail++; $display("FAIL ecall_depth1 got=%b exp=%b", ctl1, 5'b11000); end
        step();
        id_rs1          = 5'd0;
        stage_rd        = 10'd0;
        stage_reg_write = 2'b11;
        #1;
        n_checks++; if (ctl0 !== 5'b11000) begin n_fail++; $display("FAIL ecall_x0 got=%b exp=%b", ctl0, 5'b11000); end
        step();
        id_rs1          = 5'd17;
        stage_rd        = {5'd0, 5'd17};
        stage_reg_write = 2'b01;
        #1;
        n_checks++; if (ctl1 !== 5'b00100) begin n_fail++; $display("FAIL ecall_stage0 got=%b exp=%b", ctl1, 5'b00100); end
        step();
        set_idle();
        #1;
        n_checks++; if (d0_stall !== 16'd3) begin n_fail++; $display("FAIL ecall_stall0 got=%0d exp=3", d0_stall); end
        n_checks++; if (d1_stall !== 4'd2) begin n_fail++; $display("FAIL ecall_stall1 got=%0d exp=2", d1_stall); end
        $display("test_ecall done");
    endtask

    task automatic test_flush();
        set_load_use();
        ex_mispredict = 1'b1;
        #1;
        n_checks++; if (ctl0 !== 5'b11110) begin n_fail++; $display("FAIL fl_mp_ctl0 got=%b exp=%b", ctl0, 5'b11110); end
        n_checks++; if (ctl1 !== 5'b11110) begin n_fail++; $display("FAIL fl_mp_ctl1 got=%b exp=%b", ctl1, 5'b11110); end
        step();
        ex_mispredict = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (ctl1 !== 5'b11110) begin n_fail++; $display("FAIL fl_hold%0d_ctl1 got=%b exp=%b", i, ctl1, 5'b11110); end
            n_checks++; if (ctl0 !== 5'b00100) begin n_fail++; $display("FAIL fl_hold%0d_ctl0 got=%b exp=%b", i, ctl0, 5'b00100); end
            step();
        end
        #1;
        n_checks++; if (ctl1 !== 5'b00100) begin n_fail++; $display("FAIL fl_end_ctl1 got=%b exp=%b", ctl1, 5'b00100); end
        step();
        set_idle();
        #1;
        n_checks++; if (d0_stall !== 16'd6 || d0_flush !== 16'd1) begin n_fail++; $display("FAIL fl_cnt0 got=%0d/%0d exp=6/1", d0_stall, d0_flush); end
        n_checks++; if (d1_stall !== 4'd3 || d1_flush !== 4'd1) begin n_fail++; $display("FAIL fl_cnt1 got=%0d/%0d exp=3/1", d1_stall, d1_flush); end
        $display("test_flush done");
    endtask

    task automatic test_mem_wait();
        dmem_req = 1'b1;
        #1;
        n_checks++; if (ctl0 !== 5'b00001) begin n_fail++; $display("FAIL mw_c0_ctl0 got=%b exp=%b", ctl0, 5'b00001); end
        step();
        dmem_req      = 1'b0;
        ex_mispredict = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            n_checks++; if (ctl0 !== 5'b00001) begin n_fail++; $display("FAIL mw_c%0d_ctl0 got=%b exp=%b", i, ctl0, 5'b00001); end
            n_checks++; if (ctl1 !== 5'b00001) begin n_fail++; $display("FAIL mw_c%0d_ctl1 got=%b exp=%b", i, ctl1, 5'b00001); end
            step();
        end
        dmem_req   = 1'b1;
        dmem_ready = 1'b1;
        #1;
        n_checks++; if (ctl0 !== 5'b11110) begin n_fail++; $display("FAIL mw_release_ctl0 got=%b exp=%b", ctl0, 5'b11110); end
        n_checks++; if (ctl1 !== 5'b11110) begin n_fail++; $display("FAIL mw_release_ctl1 got=%b exp=%b", ctl1, 5'b11110); end
        step();
        set_idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (ctl1 !== 5'b11110) begin n_fail++; $display("FAIL mw_flush%0d_ctl1 got=%b exp=%b", i, ctl1, 5'b11110); end
            n_checks++; if (ctl0 !== 5'b11000) begin n_fail++; $display("FAIL mw_flush%0d_ctl0 got=%b exp=%b", i, ctl0, 5'b11000); end
            step();
        end
        #1;
        n_checks++; if (ctl1 !== 5'b11000) begin n_fail++; $display("FAIL mw_done_ctl1 got=%b exp=%b", ctl1, 5'b11000); end
        n_checks++; if (d0_stall !== 16'd10 || d0_flush !== 16'd2) begin n_fail++; $display("FAIL mw_cnt0 got=%0d/%0d exp=10/2", d0_stall, d0_flush); end
        n_checks++; if (d1_stall !== 4'd7 || d1_flush !== 4'd2) begin n_fail++; $display("FAIL mw_cnt1 got=%0d/%0d exp=7/2", d1_stall, d1_flush); end
        $display("test_mem_wait done");
    endtask

    task automatic test_reset_mid();
        ex_mispredict = 1'b1;
        step();
        set_idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        n_checks++; if (ctl1 !== 5'b11000) begin n_fail++; $display("FAIL rst_flush_ctl1 got=%b exp=%b", ctl1, 5'b11000); end
        n_checks++; if (d1_stall !== 4'd0 || d1_flush !== 4'd0) begin n_fail++; $display("FAIL rst_flush_cnt1 got=%0d/%0d exp=0/0", d1_stall, d1_flush); end
        dmem_req = 1'b1;
        step();
        dmem_req = 1'b0;
        reset    = 1'b0;
        step();
        reset = 1'b1;
        #1;
        n_checks++; if (ctl0 !== 5'b11000) begin n_fail++; $display("FAIL rst_mw_ctl0 got=%b exp=%b", ctl0, 5'b11000); end
        n_checks++; if (d0_stall !== 16'd0 || d0_flush !== 16'd0) begin n_fail++; $display("FAIL rst_mw_cnt0 got=%0d/%0d exp=0/0", d0_stall, d0_flush); end
        $display("test_reset_mid done");
    endtask

    task automatic test_saturation();
        set_load_use();
        for (int i = 0; i < 17; i++) step();
        set_idle();
        #1;
        n_checks++; if (d1_stall !== 4'hF) begin n_fail++; $display("FAIL sat_stall1 got=%0d exp=15", d1_stall); end
        n_checks++; if (d0_stall !== 16'd17) begin n_fail++; $display("FAIL sat_stall0 got=%0d exp=17", d0_stall); end
        ex_mispredict = 1'b1;
        for (int i = 0; i < 17; i++) step();
        set_idle();
        #1;
        n_checks++; if (d1_flush !== 4'hF) begin n_fail++; $display("FAIL sat_flush1 got=%0d exp=15", d1_flush); end
        n_checks++; if (d0_flush !== 16'd17) begin n_fail++; $display("FAIL sat_flush0 got=%0d exp=17", d0_flush); end
        n_checks++; if (d1_stall !== 4'hF) begin n_fail++; $display("FAIL sat_stall1_hold got=%0d exp=15", d1_stall); end
        $display("test_saturation done");
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        step();
        step();
        test_reset();
        test_load_use();
        test_ecall();
        test_flush();
        test_mem_wait();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
